// File: rtl/spi_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the duplex SPI slave.
//               spi_mode_t  - latched CPOL/CPHA pair for the current word
//               spi_state_t - word FSM encoding (IDLE / ACTIVE)
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // clk must run at least this many times faster than sclk so that the
    // synchronizer plus edge detector can see every sclk phase.
    localparam int MIN_OVERSAMPLE = 4;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchronizer for one asynchronous pin with
//               rise/fall detection on the synchronized value.
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_d        : asynchronous input pin
//   o_q        : synchronized level
//   o_rise     : 1-clk pulse when o_q goes 0->1
//   o_fall     : 1-clk pulse when o_q goes 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_q    = r_sync[SYNC_STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slv_duplex.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spi_slv_duplex
// Description : Full-duplex SPI slave, all four CPOL/CPHA modes, runtime word
//               length and bit order, oversampled in the clk domain.
//   clk/rst_n          : system clock (>= 4x sclk), async active-low reset
//   en                 : block enable, 0 aborts any word
//   sclk/mosi/ss       : asynchronous SPI pins (ss active low)
//   miso               : SPI data out, 0 while not in a word
//   cpol/cpha          : SPI mode, latched at word start
//   lsb_first          : bit order, latched at word start
//   cBITS_PER_WORD     : word length minus 1, latched at word start
//   txd/txd_vld/txd_rdy: transmit holding register handshake
//   rxd/rxd_vld        : received word (right aligned) and 1-clk strobe
//   tx_udr             : word started with an empty holding register
//   frm_err            : select/enable dropped with a partial word
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slv_duplex
    import spi_pkg::*;
#(
    parameter int DW          = 32,
    parameter int LOG2_DW     = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sclk,
    input  logic               mosi,
    input  logic               ss,
    output logic               miso,
    input  logic               cpol,
    input  logic               cpha,
    input  logic               lsb_first,
    input  logic [LOG2_DW-1:0] cBITS_PER_WORD,
    input  logic [DW-1:0]      txd,
    input  logic               txd_vld,
    output logic               txd_rdy,
    output logic [DW-1:0]      rxd,
    output logic               rxd_vld,
    output logic               tx_udr,
    output logic               frm_err
);

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_mosi_q, w_mosi_unused_rise, w_mosi_unused_fall;
    logic w_ss_q, w_ss_unused_rise, w_ss_unused_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(sclk),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_d(mosi),
        .o_q(w_mosi_q), .o_rise(w_mosi_unused_rise), .o_fall(w_mosi_unused_fall)
    );

    // ss idles high, so its synchronizer resets to deselected.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .i_d(ss),
        .o_q(w_ss_q), .o_rise(w_ss_unused_rise), .o_fall(w_ss_unused_fall)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    spi_state_t         r_state, w_state_next;
    spi_mode_t          r_mode;
    logic               r_lsb;
    logic [LOG2_DW-1:0] r_bpw;
    logic [LOG2_DW-1:0] r_cnt;       // rx bit counter i
    logic [LOG2_DW-1:0] r_tidx;      // tx bit counter
    logic               r_skip;      // swallow the next shift edge
    logic [DW-1:0]      r_rx_sh;
    logic [DW-1:0]      r_tx_sh;
    logic [DW-1:0]      r_hold;
    logic               r_hold_full;
    logic [DW-1:0]      r_rxd;
    logic               r_rxd_vld;
    logic               r_tx_udr;
    logic               r_frm_err;

    logic               w_go;
    logic               w_lead, w_trail, w_sample_edge, w_shift_edge;
    logic               w_start, w_abort, w_sample, w_shift, w_last;
    logic [LOG2_DW-1:0] w_rx_idx, w_tx_idx;
    logic [DW-1:0]      w_rx_next;
    logic               w_miso;

    assign w_go = en & ~w_ss_q;

    // Edges are classified with the mode latched for the current word.
    assign w_lead        = r_mode.cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail       = r_mode.cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample_edge = r_mode.cpha ? w_trail : w_lead;
    assign w_shift_edge  = r_mode.cpha ? w_lead  : w_trail;

    // MSB-first maps counter i to bit W-1-i, i.e. bpw-i.
    assign w_rx_idx = r_lsb ? r_cnt  : (r_bpw - r_cnt);
    assign w_tx_idx = r_lsb ? r_tidx : (r_bpw - r_tidx);

    always_comb begin
        w_rx_next           = r_rx_sh;
        w_rx_next[w_rx_idx] = w_mosi_q;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_go)  w_state_next = ST_ACTIVE;
            ST_ACTIVE: if (!w_go) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: control strobes and miso
    // ------------------------------------------------------------------
    always_comb begin
        w_start  = 1'b0;
        w_abort  = 1'b0;
        w_sample = 1'b0;
        w_shift  = 1'b0;
        w_last   = 1'b0;
        w_miso   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start = w_go;
            end
            ST_ACTIVE: begin
                w_miso = r_tx_sh[w_tx_idx];
                if (!w_go) begin
                    w_abort = 1'b1;
                end else begin
                    w_sample = w_sample_edge;
                    w_shift  = w_shift_edge;
                    w_last   = w_sample_edge && (r_cnt == r_bpw);
                    // A finished word restarts at once while still selected.
                    w_start  = w_last;
                end
            end
            default: ;
        endcase
    end

    assign miso = w_miso;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= '0;
            r_lsb       <= 1'b0;
            r_bpw       <= '0;
            r_cnt       <= '0;
            r_tidx      <= '0;
            r_skip      <= 1'b0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rxd       <= '0;
            r_rxd_vld   <= 1'b0;
            r_tx_udr    <= 1'b0;
            r_frm_err   <= 1'b0;
        end else begin
            r_rxd_vld <= 1'b0;
            r_tx_udr  <= 1'b0;
            r_frm_err <= 1'b0;

            if (w_abort) begin
                r_frm_err <= (r_cnt != '0);
                r_cnt     <= '0;
                r_tidx    <= '0;
            end

            if (w_sample) begin
                r_rx_sh <= w_rx_next;
                r_cnt   <= r_cnt + 1'b1;
            end

            if (w_last) begin
                r_rxd     <= w_rx_next;
                r_rxd_vld <= 1'b1;
            end

            if (w_shift) begin
                if (r_skip) begin
                    r_skip <= 1'b0;
                end else if (r_tidx != r_bpw) begin
                    r_tidx <= r_tidx + 1'b1;
                end
            end

            if (w_start) begin
                r_mode.cpol <= cpol;
                r_mode.cpha <= cpha;
                r_lsb       <= lsb_first;
                r_bpw       <= cBITS_PER_WORD;
                r_cnt       <= '0;
                r_tidx      <= '0;
                r_rx_sh     <= '0;
                // Bit 0 is already on miso at start. With cpha=1 the first
                // shift edge would skip it; on a back-to-back cpha=0 restart
                // the pending trailing edge still belongs to the old word.
                r_skip      <= cpha | (r_state == ST_ACTIVE);
                if (r_hold_full) begin
                    r_tx_sh     <= r_hold;
                    r_hold_full <= 1'b0;
                end else if (txd_vld) begin
                    r_tx_sh <= txd;
                end else begin
                    r_tx_sh  <= '0;
                    r_tx_udr <= 1'b1;
                end
            end else if (txd_vld && !r_hold_full) begin
                r_hold      <= txd;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign txd_rdy = ~r_hold_full;
    assign rxd     = r_rxd;
    assign rxd_vld = r_rxd_vld;
    assign tx_udr  = r_tx_udr;
    assign frm_err = r_frm_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slv_duplex.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_slv_duplex
// Description : Directed self-checking bench for spi_slv_duplex. A behavioural
//               SPI master drives the pins at 8x oversampling (sclk half
//               period = 4 clk) and collects miso.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slv_duplex;

    localparam int HALF = 40;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sclk;
    logic        mosi;
    logic        ss;
    logic        miso;
    logic        cpol;
    logic        cpha;
    logic        lsb_first;
    logic [4:0]  cBITS_PER_WORD;
    logic [31:0] txd;
    logic        txd_vld;
    logic        txd_rdy;
    logic [31:0] rxd;
    logic        rxd_vld;
    logic        tx_udr;
    logic        frm_err;

    int checks = 0;
    int errors = 0;

    int          n_vld = 0;
    int          n_udr = 0;
    int          n_frm = 0;
    logic [31:0] rx_log [0:15];

    spi_slv_duplex #(.DW(32), .LOG2_DW(5), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .sclk           (sclk),
        .mosi           (mosi),
        .ss             (ss),
        .miso           (miso),
        .cpol           (cpol),
        .cpha           (cpha),
        .lsb_first      (lsb_first),
        .cBITS_PER_WORD (cBITS_PER_WORD),
        .txd            (txd),
        .txd_vld        (txd_vld),
        .txd_rdy        (txd_rdy),
        .rxd            (rxd),
        .rxd_vld        (rxd_vld),
        .tx_udr         (tx_udr),
        .frm_err        (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rxd_vld) begin
            if (n_vld < 16) rx_log[n_vld] = rxd;
            n_vld++;
        end
        if (tx_udr)  n_udr++;
        if (frm_err) n_frm++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- master helpers ----------------
    task automatic spi_bits(input int w, input int nbits, input logic [31:0] tx,
                            output logic [31:0] rx);
        int idx;
        rx = '0;
        for (int b = 0; b < nbits; b++) begin
            idx = lsb_first ? b : (w - 1 - b);
            if (!cpha) begin
                mosi = tx[idx];
                #HALF; sclk = ~cpol; rx[idx] = miso;
                #HALF; sclk = cpol;
            end else begin
                sclk = ~cpol; mosi = tx[idx];
                #HALF; sclk = cpol; rx[idx] = miso;
                #HALF;
            end
        end
    endtask

    task automatic set_mode(input logic p, input logic h, input logic l, input logic [4:0] b);
        @(negedge clk);
        cpol = p; cpha = h; lsb_first = l; cBITS_PER_WORD = b; sclk = p;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_start();
        ss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        #HALF;
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic load_txd(input logic [31:0] v);
        @(negedge clk);
        txd = v; txd_vld = 1'b1;
        @(negedge clk);
        txd_vld = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++; if (miso !== 1'b0)    begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
        checks++; if (txd_rdy !== 1'b1) begin errors++; $display("FAIL reset_txd_rdy got %b exp 1", txd_rdy); end
        checks++; if (rxd !== 32'h0)    begin errors++; $display("FAIL reset_rxd got %h exp 0", rxd); end
        checks++; if (rxd_vld !== 1'b0) begin errors++; $display("FAIL reset_rxd_vld got %b exp 0", rxd_vld); end
        checks++; if (tx_udr !== 1'b0)  begin errors++; $display("FAIL reset_tx_udr got %b exp 0", tx_udr); end
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err got %b exp 0", frm_err); end
    endtask

    task automatic test_mode0_basic();
        logic [31:0] mr;
        int v0;
        set_mode(1'b0, 1'b0, 1'b0, 5'd7);
        load_txd(32'h0000_00A5);
        checks++; if (txd_rdy !== 1'b0) begin errors++; $display("FAIL basic_hold_full got %b exp 0", txd_rdy); end
        v0 = n_vld;
        frame_start();
        checks++; if (txd_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy_after_start got %b exp 1", txd_rdy); end
        spi_bits(8, 8, 32'h0000_003C, mr);
        frame_end();
        checks++; if (rxd !== 32'h0000_003C) begin errors++; $display("FAIL basic_rxd got %h exp 0000003c", rxd); end
        checks++; if (n_vld - v0 !== 1) begin errors++; $display("FAIL basic_vld_count got %0d exp 1", n_vld - v0); end
        checks++; if (mr !== 32'h0000_00A5) begin errors++; $display("FAIL basic_miso got %h exp 000000a5", mr); end
    endtask

    task automatic test_modes();
        logic [31:0] mr;
        int v0;
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b1, 5'd31);
            load_txd(32'h1234_5678);
            v0 = n_vld;
            frame_start();
            spi_bits(32, 32, 32'hDEAD_BEEF, mr);
            frame_end();
            checks++; if (rxd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mode%0d_rxd got %h exp deadbeef", m, rxd); end
            checks++; if (mr !== 32'h1234_5678) begin errors++; $display("FAIL mode%0d_miso got %h exp 12345678", m, mr); end
            checks++; if (n_vld - v0 !== 1) begin errors++; $display("FAIL mode%0d_vld_count got %0d exp 1", m, n_vld - v0); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mw  [3];
        logic [31:0] tv  [4];
        logic [31:0] mr  [3];
        int v0, u0;
        mw[0] = 32'h1234; mw[1] = 32'hBEEF; mw[2] = 32'h0F0F;
        tv[0] = 32'hAAAA; tv[1] = 32'h5555; tv[2] = 32'hC33C; tv[3] = 32'h0000_7E7E;
        set_mode(1'b0, 1'b0, 1'b0, 5'd15);
        load_txd(tv[0]);
        v0 = n_vld; u0 = n_udr;
        frame_start();
        fork
            begin
                for (int k = 0; k < 3; k++) spi_bits(16, 16, mw[k], mr[k]);
            end
            begin
                for (int k = 1; k < 4; k++) begin
                    int t;
                    t = 0;
                    while (!txd_rdy && t < 3000) begin @(negedge clk); t++; end
                    if (!txd_rdy) begin
                        checks++; errors++;
                        $display("FAIL b2b_refill_timeout got rdy=%b exp 1", txd_rdy);
                    end else begin
                        txd = tv[k]; txd_vld = 1'b1;
                        @(negedge clk);
                        txd_vld = 1'b0;
                    end
                end
            end
        join
        frame_end();
        checks++; if (n_vld - v0 !== 3) begin errors++; $display("FAIL b2b_vld_count got %0d exp 3", n_vld - v0); end
        checks++; if (n_udr - u0 !== 0) begin errors++; $display("FAIL b2b_udr_count got %0d exp 0", n_udr - u0); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (mr[k] !== tv[k]) begin errors++; $display("FAIL b2b_miso%0d got %h exp %h", k, mr[k], tv[k]); end
            checks++; if (rx_log[(v0 + k) % 16] !== mw[k]) begin errors++; $display("FAIL b2b_rxd%0d got %h exp %h", k, rx_log[(v0 + k) % 16], mw[k]); end
        end
    endtask

    task automatic test_underrun();
        logic [31:0] mr;
        int u0;
        set_mode(1'b0, 1'b0, 1'b0, 5'd7);
        checks++; if (txd_rdy !== 1'b1) begin errors++; $display("FAIL udr_hold_empty got %b exp 1", txd_rdy); end
        u0 = n_udr;
        frame_start();
        checks++; if (n_udr - u0 !== 1) begin errors++; $display("FAIL udr_pulse got %0d exp 1", n_udr - u0); end
        spi_bits(8, 8, 32'h0000_0096, mr);
        frame_end();
        checks++; if (mr !== 32'h0) begin errors++; $display("FAIL udr_miso got %h exp 00000000", mr); end
        checks++; if (rxd !== 32'h0000_0096) begin errors++; $display("FAIL udr_rxd got %h exp 00000096", rxd); end
    endtask

    task automatic test_frame_error();
        logic [31:0] mr;
        int v0, f0;
        set_mode(1'b0, 1'b0, 1'b0, 5'd7);
        v0 = n_vld; f0 = n_frm;
        frame_start();
        spi_bits(8, 5, 32'h0000_00FF, mr);
        frame_end();
        checks++; if (n_frm - f0 !== 1) begin errors++; $display("FAIL frm_pulse got %0d exp 1", n_frm - f0); end
        checks++; if (n_vld - v0 !== 0) begin errors++; $display("FAIL frm_no_vld got %0d exp 0", n_vld - v0); end
        v0 = n_vld;
        frame_start();
        spi_bits(8, 8, 32'h0000_005A, mr);
        frame_end();
        checks++; if (rxd !== 32'h0000_005A) begin errors++; $display("FAIL frm_next_rxd got %h exp 0000005a", rxd); end
        checks++; if (n_vld - v0 !== 1) begin errors++; $display("FAIL frm_next_vld got %0d exp 1", n_vld - v0); end
    endtask

    task automatic test_reset_midword();
        logic [31:0] mr;
        int v0;
        set_mode(1'b0, 1'b0, 1'b0, 5'd7);
        load_txd(32'h0000_00FF);
        frame_start();
        load_txd(32'h0000_0011);
        spi_bits(8, 3, 32'h0000_00FF, mr);
        repeat (4) @(negedge clk);
        checks++; if (miso !== 1'b1)    begin errors++; $display("FAIL rstmid_pre_miso got %b exp 1", miso); end
        checks++; if (txd_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_pre_rdy got %b exp 0", txd_rdy); end
        rst_n = 1'b0;
        #1;
        checks++; if (miso !== 1'b0)    begin errors++; $display("FAIL rstmid_miso got %b exp 0", miso); end
        checks++; if (txd_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_txd_rdy got %b exp 1", txd_rdy); end
        checks++; if (rxd !== 32'h0)    begin errors++; $display("FAIL rstmid_rxd got %h exp 0", rxd); end
        checks++; if (rxd_vld !== 1'b0 || tx_udr !== 1'b0 || frm_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_pulses got %b%b%b exp 000", rxd_vld, tx_udr, frm_err);
        end
        repeat (3) @(negedge clk);
        ss = 1'b1; sclk = 1'b0;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        v0 = n_vld;
        frame_start();
        spi_bits(8, 8, 32'h0000_00C3, mr);
        frame_end();
        checks++; if (rxd !== 32'h0000_00C3) begin errors++; $display("FAIL rstmid_next_rxd got %h exp 000000c3", rxd); end
        checks++; if (n_vld - v0 !== 1) begin errors++; $display("FAIL rstmid_next_vld got %0d exp 1", n_vld - v0); end
    endtask

    initial begin
        en = 1'b1; rst_n = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; cBITS_PER_WORD = 5'd7;
        txd = '0; txd_vld = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_mode0_basic();
        test_modes();
        test_back_to_back();
        test_underrun();
        test_frame_error();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
